// File: rtl/dm_arbiter_if.sv
// Bundle between the data-memory arbiter and its environment.
// The slave side is the arbiter; the master side is the two requesters plus the DM macro.
interface dm_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_cen_n;
    logic              mem_wen_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_cen_n, mem_wen_n, mem_addr, mem_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_cen_n, mem_wen_n, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the core load/store port (0) and the
// loader/debug port (1); port 1 wins after MAX_HOLD consecutive contested losses.
module dm_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    dm_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, P0, P1} own_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    own_t        own, own_nxt;
    logic [3:0]  hold, hold_nxt;
    logic        gnt0, gnt1;
    logic        rd_pend, rd_port;
    logic        rvalid0, rvalid1;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        own_nxt  = IDLE;
        hold_nxt = '0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (rst_n) begin
            case ({bus.m0_req, bus.m1_req})
                2'b10: begin
                    gnt0    = 1'b1;
                    own_nxt = P0;
                end
                2'b01: begin
                    gnt1    = 1'b1;
                    own_nxt = P1;
                end
                2'b11: begin
                    if (hold == HOLD_MAX) begin
                        gnt1    = 1'b1;
                        own_nxt = P1;
                    end else begin
                        gnt0     = 1'b1;
                        own_nxt  = P0;
                        hold_nxt = hold + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The selected port drives the macro; an idle cycle parks the bus at all-zero.
    always_comb begin
        sel_addr      = '0;
        sel_wdata     = '0;
        bus.mem_cen_n = 1'b1;
        bus.mem_wen_n = 1'b1;
        if (gnt1) begin
            sel_addr      = bus.m1_addr;
            sel_wdata     = bus.m1_wdata;
            bus.mem_cen_n = 1'b0;
            bus.mem_wen_n = ~bus.m1_we;
        end else if (gnt0) begin
            sel_addr      = bus.m0_addr;
            sel_wdata     = bus.m0_wdata;
            bus.mem_cen_n = 1'b0;
            bus.mem_wen_n = ~bus.m0_we;
        end
        bus.mem_addr  = sel_addr;
        bus.mem_wdata = sel_wdata;
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own     <= IDLE;
            hold    <= '0;
            rd_pend <= 1'b0;
            rd_port <= 1'b0;
        end else begin
            own     <= own_nxt;
            hold    <= hold_nxt;
            rd_pend <= (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
            rd_port <= gnt1;
        end
    end

    assign rvalid0 = rd_pend & ~rd_port;
    assign rvalid1 = rd_pend &  rd_port;

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0;
    assign bus.m1_rvalid = rvalid1;
    assign bus.m0_rdata  = rvalid0 ? bus.mem_rdata : '0;
    assign bus.m1_rdata  = rvalid1 ? bus.mem_rdata : '0;

    // Only contested port-0 wins can leave hold non-zero.
    own_hold_consistent: assert property (
        @(posedge clk) disable iff (!rst_n) (own == P0) || (hold == '0)
    );
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a wait-age / shadow-memory model of the arbiter.
module tb_dm_arbiter;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    dm_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // DM macro: one-cycle read latency; rdata is noise when no read was issued.
    bit [31:0] dm_mem [65536];
    always @(posedge clk) begin
        if (!bus.mem_cen_n && !bus.mem_wen_n)
            dm_mem[bus.mem_addr] <= bus.mem_wdata;
        if (!bus.mem_cen_n && bus.mem_wen_n)
            bus.mem_rdata <= dm_mem[bus.mem_addr];
        else
            bus.mem_rdata <= $urandom;
    end

    // Reference model: port-1 wait age, pending-return record, shadow memory.
    bit [31:0] ref_mem [65536];
    int        p1_waited = 0;
    bit        pend_v    = 0;
    bit        pend_port = 0;
    bit [31:0] pend_data = 0;
    int unsigned rst_cnt  = 0;
    int unsigned rst_seen = 0;

    always @(negedge rst_n) rst_cnt++;

    always @(negedge clk) begin
        bit        e0, e1;
        bit [49:0] exp_bus;
        #2;
        if (!rst_n) begin
            check("rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 2'b00);
            check("rst_mem", {bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.mem_wdata},
                  {2'b11, 48'h0});
            check("rst_ret", {bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_rdata}, 0);
            p1_waited = 0;
            pend_v    = 0;
            rst_seen  = rst_cnt;
        end else begin
            if (rst_cnt != rst_seen) begin
                p1_waited = 0;
                pend_v    = 0;
                rst_seen  = rst_cnt;
            end
            e1 = bus.m1_req && (!bus.m0_req || p1_waited == MAX_HOLD);
            e0 = bus.m0_req && !e1;
            check("gnt", {bus.m0_gnt, bus.m1_gnt}, {e0, e1});

            if (e1)      exp_bus = {1'b0, !bus.m1_we, bus.m1_addr, bus.m1_wdata};
            else if (e0) exp_bus = {1'b0, !bus.m0_we, bus.m0_addr, bus.m0_wdata};
            else         exp_bus = {2'b11, 48'h0};
            check("mem_bus", {bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr, bus.mem_wdata},
                  exp_bus);

            check("rvalid", {bus.m0_rvalid, bus.m1_rvalid},
                  {pend_v && !pend_port, pend_v && pend_port});
            check("m0_rdata", bus.m0_rdata, (pend_v && !pend_port) ? pend_data : 32'h0);
            check("m1_rdata", bus.m1_rdata, (pend_v &&  pend_port) ? pend_data : 32'h0);

            p1_waited = (bus.m1_req && !e1) ? p1_waited + 1 : 0;
            pend_v    = (e0 && !bus.m0_we) || (e1 && !bus.m1_we);
            pend_port = e1;
            pend_data = ref_mem[e1 ? bus.m1_addr : bus.m0_addr];
            if (e0 && bus.m0_we) ref_mem[bus.m0_addr] = bus.m0_wdata;
            if (e1 && bus.m1_we) ref_mem[bus.m1_addr] = bus.m1_wdata;
        end
    end

    task automatic set_m0(input logic req, input logic we, input logic [15:0] a,
                          input logic [31:0] d);
        bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [15:0] a,
                          input logic [31:0] d);
        bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, 16'h0, 32'h0);
        set_m1(1'b0, 1'b0, 16'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        int         n0;
        bit         keep0, keep1;

        idle();
        bus.mem_rdata = 32'h0;

        // Reset held with port 0 requesting
        set_m0(1'b1, 1'b0, 16'h0, 32'h0);
        repeat (3) @(negedge clk);
        #3;
        check("rst_m0_gnt", bus.m0_gnt, 1'b0);
        check("rst_cen_wen", {bus.mem_cen_n, bus.mem_wen_n}, 2'b11);
        check("rst_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("rel_m0_gnt", bus.m0_gnt, 1'b1);

        // Single write then read by port 1
        @(negedge clk);
        idle();
        set_m1(1'b1, 1'b1, 16'h0005, 32'hDEADBEEF);
        #3;
        check("wr_bus", {bus.mem_cen_n, bus.mem_wen_n, bus.mem_addr}, {2'b00, 16'h0005});
        @(negedge clk);
        set_m1(1'b1, 1'b0, 16'h0005, 32'h0);
        #3;
        check("rd_m1_gnt", bus.m1_gnt, 1'b1);
        @(negedge clk);
        idle();
        #3;
        check("rd_rvalid", bus.m1_rvalid, 1'b1);
        check("rd_rdata", bus.m1_rdata, 32'hDEADBEEF);
        check("rd_m0_rdata", bus.m0_rdata, 32'h0);

        // Starvation bound with both ports saturated
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_m0(1'b1, 1'b0, 16'(i + 16), 32'h0);
            set_m1(1'b1, 1'b0, 16'h0020, 32'h0);
            #3;
            pat[i] = bus.m1_gnt;
        end
        check("starve_pattern", pat, 10'b10_0001_0000);

        // Pipelined mixed reads
        @(negedge clk);
        idle();
        set_m0(1'b1, 1'b1, 16'h0001, 32'h11);
        @(negedge clk);
        idle();
        set_m1(1'b1, 1'b1, 16'h0002, 32'h22);
        @(negedge clk);
        idle();
        @(negedge clk);
        set_m0(1'b1, 1'b0, 16'h0001, 32'h0);
        #3;
        check("pipe_n_gnt", bus.m0_gnt, 1'b1);
        @(negedge clk);
        idle();
        set_m1(1'b1, 1'b0, 16'h0002, 32'h0);
        #3;
        check("pipe_n1", {bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata, bus.m1_gnt},
              {2'b10, 32'h11, 1'b1});
        @(negedge clk);
        idle();
        #3;
        check("pipe_n2", {bus.m0_rvalid, bus.m1_rvalid, bus.m1_rdata}, {2'b01, 32'h22});

        // Write-then-read ordering with hold driven to its limit
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            set_m0(1'b1, 1'b0, 16'h0007, 32'h0);
            set_m1(1'b1, 1'b1, 16'h0003, 32'h5A5A5A5A);
            #3;
            check("wtr_pre_m0", bus.m0_gnt, 1'b1);
        end
        @(negedge clk);
        set_m0(1'b1, 1'b0, 16'h0003, 32'h0);
        #3;
        check("wtr_m1_first", {bus.m0_gnt, bus.m1_gnt}, 2'b01);
        @(negedge clk);
        set_m1(1'b0, 1'b0, 16'h0, 32'h0);
        #3;
        check("wtr_m0_next", bus.m0_gnt, 1'b1);
        @(negedge clk);
        idle();
        #3;
        check("wtr_rdata", {bus.m0_rvalid, bus.m0_rdata}, {1'b1, 32'h5A5A5A5A});

        // Reset pulse while a port-0 read is outstanding
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_m0(1'b1, 1'b0, 16'h0008, 32'h0);
            set_m1(1'b1, 1'b0, 16'h0009, 32'h0);
            #3;
            check("mid_pre_m0", bus.m0_gnt, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        idle();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        set_m0(1'b1, 1'b0, 16'h0008, 32'h0);
        set_m1(1'b1, 1'b0, 16'h0009, 32'h0);
        #3;
        check("mid_no_rvalid", {bus.m0_rvalid, bus.m1_rvalid}, 2'b00);
        n0 = 0;
        for (int i = 0; i < 10 && !bus.m1_gnt; i++) begin
            if (bus.m0_gnt) n0++;
            @(negedge clk);
            #3;
        end
        check("mid_hold_cleared", n0, MAX_HOLD);

        // Randomized traffic: requests are held until granted, occasionally dropped
        keep0 = 0;
        keep1 = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!keep0 || $urandom_range(0, 15) == 0)
                set_m0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       16'($urandom_range(0, 7)), $urandom);
            if (!keep1 || $urandom_range(0, 15) == 0)
                set_m1($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)),
                       16'($urandom_range(0, 7)), $urandom);
            #3;
            keep0 = bus.m0_req && !bus.m0_gnt;
            keep1 = bus.m1_req && !bus.m1_gnt;
        end

        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
